// File: rtl/instr_sequencer.sv
// instr_sequencer: PC owner, program fetch over req/ack, IR issue and flow control with return stack.
// Define SEQ_PERF_EN to add the saturating 16-bit retired_cnt output.
module instr_sequencer #(
  parameter int PC_W        = 12,
  parameter int IR_W        = 24,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [IR_W-1:0] pm_data,
  output logic [IR_W-1:0] ir,
  output logic            ir_valid,
  input  logic            exec_done,
  input  logic            zero_flag,
  input  logic            carry_flag,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            halted,
`ifdef SEQ_PERF_EN
  output logic            fault,
  output logic [15:0]     retired_cnt
`else
  output logic            fault
`endif
);
  localparam int IX_W = $clog2(STACK_DEPTH);
  localparam int SP_W = IX_W + 1;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, UPDATE, HALTED, FAULT} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, target;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              fault_q, fault_d, push, is_flow;
  logic [6:0]        op;
  logic [IX_W-1:0]   wr_idx, top_idx;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  // Flow-control group is the 0x1xxxxx page; bit 19 is a don't-care.
  assign is_flow = ir_q[23:20] == 4'b0001;
  assign op      = ir_q[18:12];
  assign target  = PC_W'(ir_q[11:0]);
  assign pc_inc  = pc_q + 1'b1;
  assign wr_idx  = IX_W'(sp_q);
  assign top_idx = IX_W'(sp_q - 1'b1);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    push    = 1'b0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (pm_ack) begin
        ir_d    = pm_data;
        state_d = ISSUE;
      end
      ISSUE:  state_d = EXEC;
      EXEC:   state_d = exec_done ? UPDATE : EXEC;
      UPDATE: begin
        state_d = halt ? HALTED : FETCH;
        pc_d    = pc_inc;
        if (is_flow) begin
          case (op)
            7'd0: pc_d = target;
            7'd1: pc_d = zero_flag ? target : pc_inc;
            7'd2: pc_d = zero_flag ? pc_inc : target;
            7'd3: pc_d = carry_flag ? target : pc_inc;
            7'd4: if (sp_q == '0) begin
              fault_d = 1'b1;
              state_d = FAULT;
              pc_d    = pc_q;
            end else begin
              sp_d = sp_q - 1'b1;
              pc_d = stack_q[top_idx];
            end
            7'd5: if (sp_q == SP_W'(STACK_DEPTH)) begin
              fault_d = 1'b1;
              state_d = FAULT;
              pc_d    = pc_q;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
              pc_d = target;
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      HALTED: state_d = halt ? HALTED : FETCH;
      FAULT:  state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= pc_inc;
  end
`ifdef SEQ_PERF_EN
  logic [15:0] retired_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retired_q <= '0;
    else if (state_q == UPDATE && state_d != FAULT && retired_q != 16'hFFFF) retired_q <= retired_q + 1'b1;
  end
  assign retired_cnt = retired_q;
`endif
  assign pm_req   = state_q == FETCH;
  assign pm_addr  = pm_req ? pc_q : '0;
  assign ir       = ir_q;
  assign ir_valid = state_q == ISSUE;
  assign halted   = state_q == HALTED;
  assign fault    = fault_q;
  assign pc       = pc_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random instruction streams checked against a queue-based sequencer model.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pm_req, pm_ack = 1'b0;
  logic [11:0] pm_addr, pc;
  logic [23:0] pm_data = '0, ir;
  logic        ir_valid, exec_done = 1'b0, zero_flag = 1'b0, carry_flag = 1'b0, halt = 1'b0;
  logic        halted, fault;
  int          n_assert = 0, n_fail = 0;
  int          mpc = 0, mret = 0;
  int          stk[$];
  bit          mfault = 0;
  int          cyc = 0, last_iv = -1;
  bit          chk_period = 0;
`ifdef SEQ_PERF_EN
  logic [15:0] retired_cnt;
`endif

  instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack),
    .pm_data(pm_data), .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halt(halt), .pc(pc), .halted(halted),
`ifdef SEQ_PERF_EN
    .retired_cnt(retired_cnt),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    reset_n = 1'b0;
    pm_ack = 1'b0; exec_done = 1'b0; halt = 1'b0;
    @(negedge clk);
    if (check) begin
      chk("rst_pm_req", pm_req, 0);
      chk("rst_pm_addr", pm_addr, 0);
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fault", fault, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
    end
    reset_n = 1'b1;
    mpc = 0; mret = 0; mfault = 0; stk.delete(); last_iv = -1;
  endtask

  // Architectural effect of one retired instruction.
  task automatic model_update(input logic [23:0] ins, input bit z, input bit cy);
    int nxt, tgt, op;
    nxt = (mpc + 1) % 4096;
    tgt = int'(ins[11:0]);
    op  = int'(ins[18:12]);
    if (ins[23:20] == 4'h1) begin
      if (op == 0) nxt = tgt;
      else if (op == 1 && z) nxt = tgt;
      else if (op == 2 && !z) nxt = tgt;
      else if (op == 3 && cy) nxt = tgt;
      else if (op == 4) begin
        if (stk.size() == 0) begin mfault = 1; nxt = mpc; end
        else nxt = stk.pop_back();
      end else if (op == 5) begin
        if (stk.size() == 4) begin mfault = 1; nxt = mpc; end
        else begin stk.push_back(nxt); nxt = tgt; end
      end
    end
    mpc = nxt;
    if (!mfault && mret < 65535) mret++;
  endtask

  task automatic run_instr(input logic [23:0] ins, input int dly, input int xwait,
                           input bit z, input bit cy, input bit hl);
    int n = 0;
    while (pm_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("fetch_req", pm_req, 1);
    chk("fetch_addr", pm_addr, mpc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("stall_req", pm_req, 1);
      chk("stall_addr", pm_addr, mpc);
    end
    pm_ack = 1'b1; pm_data = ins;
    @(negedge clk);
    pm_ack = 1'b0; pm_data = 24'($urandom);
    chk("ir_valid", ir_valid, 1);
    chk("ir", ir, ins);
    if (chk_period && last_iv >= 0) chk("period", cyc - last_iv, 4);
    last_iv = cyc;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk("ir_valid_1cyc", ir_valid, 0);
    repeat (xwait) @(negedge clk);
    exec_done = 1'b1; zero_flag = !z; carry_flag = !cy; halt = hl;
    @(negedge clk);
    exec_done = 1'b0; zero_flag = z; carry_flag = cy;
    @(negedge clk);
    model_update(ins, z, cy);
    chk("pc", pc, mpc);
    chk("fault", fault, mfault);
`ifdef SEQ_PERF_EN
    chk("retired", retired_cnt, mret);
`endif
    if (mfault) begin
      halt = 1'b0;
      repeat (3) @(negedge clk);
      chk("fault_req", pm_req, 0);
      chk("fault_iv", ir_valid, 0);
      chk("fault_sticky", fault, 1);
    end else if (hl) begin
      chk("halted", halted, 1);
      chk("halt_req", pm_req, 0);
      repeat (2) @(negedge clk);
      chk("halted_hold", halted, 1);
      halt = 1'b0;
      @(negedge clk);
      chk("resume_req", pm_req, 1);
      chk("resume_addr", pm_addr, mpc);
      chk("resume_halted", halted, 0);
    end else begin
      chk("next_req", pm_req, 1);
    end
  endtask

  initial begin
    logic [23:0] ins;
    // linear fetch with minimum period
    do_reset(1);
    chk_period = 1;
    for (int i = 0; i < 3; i++) run_instr(24'h200000, 0, 0, 0, 0, 0);
    chk_period = 0;
    chk("linear_pc", pc, 12'h003);
    // conditional branch, not taken then taken
    do_reset(0);
    run_instr(24'h10100A, 0, 0, 0, 0, 0);
    chk("jze_nt_addr", pm_addr, 12'h001);
    do_reset(0);
    run_instr(24'h10100A, 0, 0, 1, 0, 0);
    chk("jze_t_addr", pm_addr, 12'h00A);
    // call / return
    do_reset(0);
    run_instr(24'h105010, 0, 0, 0, 0, 0);
    chk("bsr_addr", pm_addr, 12'h010);
    run_instr(24'h104000, 0, 0, 0, 0, 0);
    chk("ret_addr", pm_addr, 12'h001);
    chk("ret_fault", fault, 0);
    // stack overflow on the fifth nested call
    do_reset(0);
    for (int i = 0; i < 5; i++) run_instr(24'h105000 | 24'(i * 16 + 16), 0, 0, 0, 0, 0);
    chk("ovf_fault", fault, 1);
    chk("ovf_req", pm_req, 0);
    // underflow
    do_reset(0);
    run_instr(24'h104000, 0, 0, 0, 0, 0);
    chk("unf_fault", fault, 1);
    // stalled ack and halt during exec
    do_reset(0);
    run_instr(24'h200000, 5, 2, 0, 0, 1);
    run_instr(24'h300000, 0, 0, 0, 0, 0);
    // pc wrap
    do_reset(0);
    run_instr(24'h100FFF, 0, 0, 0, 0, 0);
    run_instr(24'h200000, 0, 0, 0, 0, 0);
    chk("wrap_addr", pm_addr, 12'h000);
    // reset mid-fetch
    do_reset(0);
    run_instr(24'h100123, 0, 0, 0, 0, 0);
    chk("mid_req_before", pm_req, 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_req_async", pm_req, 0);
    chk("mid_pc", pc, 0);
    @(negedge clk);
    do_reset(0);
    // random streams
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ins = {4'h1, 1'($urandom), 7'($urandom_range(0, 5)), 12'($urandom)};
        6:       ins = {4'h1, 1'($urandom), 7'($urandom_range(6, 127)), 12'($urandom)};
        default: ins = 24'($urandom);
      endcase
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                $urandom_range(0, 7) == 0);
      if (mfault) do_reset(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
